// File: rtl/count_pkg.sv
// Shared constants and types for the up/down counter family.
//
// DIR_*  : encoding of the dir input (1 = up, 0 = down).
// MODE_* : encoding of the sat input (0 = wrap, 1 = saturate).
// op_e   : the operation selected for the coming edge, in priority order.
// clamp  : min(value, limit), used when loading.
package count_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    typedef enum logic [1:0] {
        OpHold,
        OpCount,
        OpLoad,
        OpReset
    } op_e;

    // Helper used when loading; returns the smaller of the two values.
    function automatic logic [31:0] clamp32(input logic [31:0] value, input logic [31:0] limit);
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/count_next.sv
// Combinational next-count logic for one enabled step.
//
// Ports:
//   out     : current count
//   limit   : top of the range 0..limit
//   dir     : DIR_UP / DIR_DOWN
//   sat     : MODE_WRAP / MODE_SAT
//   nxt     : count after one enabled step
//   at_end  : current count sits at (or past) the end in the chosen direction
//   do_wrap : this step wraps around the range
//   blocked : this step is suppressed by saturation
module count_next
    import count_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] out,
    input  logic [WIDTH-1:0] limit,
    input  logic             dir,
    input  logic             sat,
    output logic [WIDTH-1:0] nxt,
    output logic             at_end,
    output logic             do_wrap,
    output logic             blocked
);

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO = '0;

    always_comb begin
        nxt     = out;
        at_end  = 1'b0;
        do_wrap = 1'b0;
        blocked = 1'b0;

        if (dir == DIR_UP) begin
            // ">=" so a count left above a lowered limit still terminates
            at_end = (out >= limit);
            if (!at_end) begin
                // out < limit, so out + 1 cannot overflow WIDTH bits
                nxt = out + ONE;
            end else if (sat == MODE_SAT) begin
                nxt     = limit;
                blocked = 1'b1;
            end else begin
                nxt     = ZERO;
                do_wrap = 1'b1;
            end
        end else begin
            at_end = (out == ZERO);
            if (!at_end) begin
                // Counts down normally even when out > limit
                nxt = out - ONE;
            end else if (sat == MODE_SAT) begin
                nxt     = ZERO;
                blocked = 1'b1;
            end else begin
                nxt     = limit;
                do_wrap = 1'b1;
            end
        end
    end

endmodule

// File: rtl/updown_count_n.sv
// Parametrised up/down counter with programmable terminal value, wrap or
// saturate mode, cascade terminal count, wrap pulse and sticky overflow.
//
// Parameters:
//   WIDTH     : counter width in bits (>= 2)
//   RESET_VAL : value of out after reset
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   en    : count enable (ignored while load is high)
//   dir   : 1 = up, 0 = down
//   load  : synchronous load of min(in, limit)
//   in    : load value
//   limit : terminal count, range is 0..limit
//   sat   : 1 = saturate at range ends, 0 = wrap
//   out   : registered count
//   tc    : combinational terminal count, for cascading into the next en
//   wrap  : registered one-cycle pulse after a wrapping edge
//   ovf   : sticky flag, a step was blocked by saturation
module updown_count_n
    import count_pkg::*;
#(
    parameter int unsigned          WIDTH     = 8,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] in,
    input  logic [WIDTH-1:0] limit,
    input  logic             sat,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    logic [WIDTH-1:0] out_q, out_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] step_nxt;
    logic             step_at_end;
    logic             step_wrap;
    logic             step_blocked;
    logic [WIDTH-1:0] load_val;
    op_e              op;

    count_next #(
        .WIDTH (WIDTH)
    ) u_count_next (
        .out     (out_q),
        .limit   (limit),
        .dir     (dir),
        .sat     (sat),
        .nxt     (step_nxt),
        .at_end  (step_at_end),
        .do_wrap (step_wrap),
        .blocked (step_blocked)
    );

    // Loads never place the count above the current limit
    assign load_val = (in > limit) ? limit : in;

    // Priority: rst > load > en > hold
    always_comb begin
        op = OpHold;
        if (rst) begin
            op = OpReset;
        end else if (load) begin
            op = OpLoad;
        end else if (en) begin
            op = OpCount;
        end
    end

    always_comb begin
        out_d  = out_q;
        wrap_d = 1'b0;
        ovf_d  = ovf_q;
        unique case (op)
            OpReset: begin
                out_d = RESET_VAL;
                ovf_d = 1'b0;
            end
            OpLoad: begin
                out_d = load_val;
                ovf_d = 1'b0;
            end
            OpCount: begin
                out_d  = step_nxt;
                wrap_d = step_wrap;
                ovf_d  = ovf_q | step_blocked;
            end
            OpHold: begin
                out_d = out_q;
            end
            default: begin
                out_d = out_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        out_q  <= out_d;
        wrap_q <= wrap_d;
        ovf_q  <= ovf_d;
    end

    assign out  = out_q;
    assign wrap = wrap_q;
    assign ovf  = ovf_q;
    // Asserted regardless of sat so a saturating lower stage still ripples
    assign tc   = en & ~load & step_at_end;

endmodule

// File: tb/tb_updown_count_n.sv
module tb_updown_count_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main 8-bit instance
    logic       rst = 1'b0, en = 1'b0, dir = 1'b1, load = 1'b0, sat = 1'b0;
    logic [7:0] d_in = 8'd0, limit = 8'hFF;
    logic [7:0] out;
    logic       tc, wrap, ovf;

    updown_count_n #(.WIDTH(8), .RESET_VAL(8'd0)) dut (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .in(d_in),
        .limit(limit), .sat(sat), .out(out), .tc(tc), .wrap(wrap), .ovf(ovf)
    );

    // Cascaded pair of 4-bit instances
    logic       c_rst = 1'b1, c_en = 1'b0;
    logic [3:0] lo_out, hi_out;
    logic       lo_tc, hi_tc, lo_wrap, hi_wrap, lo_ovf, hi_ovf;

    updown_count_n #(.WIDTH(4), .RESET_VAL(4'd0)) dut_lo (
        .clk(clk), .rst(c_rst), .en(c_en), .dir(1'b1), .load(1'b0), .in(4'd0),
        .limit(4'd15), .sat(1'b0), .out(lo_out), .tc(lo_tc), .wrap(lo_wrap), .ovf(lo_ovf)
    );
    updown_count_n #(.WIDTH(4), .RESET_VAL(4'd0)) dut_hi (
        .clk(clk), .rst(c_rst), .en(lo_tc), .dir(1'b1), .load(1'b0), .in(4'd0),
        .limit(4'd15), .sat(1'b0), .out(hi_out), .tc(hi_tc), .wrap(hi_wrap), .ovf(hi_ovf)
    );

    // 16-bit instance with a small limit and nonzero reset value
    logic        w_rst = 1'b1, w_en = 1'b0;
    logic [15:0] w_out;
    logic        w_tc, w_wrap, w_ovf;

    updown_count_n #(.WIDTH(16), .RESET_VAL(16'd2)) dut_w (
        .clk(clk), .rst(w_rst), .en(w_en), .dir(1'b1), .load(1'b0), .in(16'd0),
        .limit(16'd3), .sat(1'b0), .out(w_out), .tc(w_tc), .wrap(w_wrap), .ovf(w_ovf)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model of the main instance, in plain integers
    int unsigned m_out  = 0;
    bit          m_wrap = 0;
    bit          m_ovf  = 0;
    bit          exp_tc, obs_tc;

    task automatic model_step();
        int unsigned lim = limit;
        m_wrap = 0;
        if (rst) begin
            m_out = 0; m_ovf = 0;
        end else if (load) begin
            m_out = (d_in > lim) ? lim : d_in;
            m_ovf = 0;
        end else if (en) begin
            if (dir) begin
                if (m_out < lim)  m_out = m_out + 1;
                else if (sat)     begin m_out = lim; m_ovf = 1; end
                else              begin m_out = 0; m_wrap = 1; end
            end else begin
                if (m_out > 0)    m_out = m_out - 1;
                else if (sat)     m_ovf = 1;
                else              begin m_out = lim; m_wrap = 1; end
            end
        end
    endtask

    // Samples tc before the edge, advances one clock, updates the model
    task automatic tick();
        #1;
        exp_tc = en && !load && ((dir && m_out >= limit) || (!dir && m_out == 0));
        obs_tc = tc;
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic set_in(input logic r, input logic e, input logic d, input logic l,
                          input logic [7:0] v, input logic [7:0] lim, input logic s);
        rst = r; en = e; dir = d; load = l; d_in = v; limit = lim; sat = s;
    endtask

    task automatic test_reset();
        set_in(1, 1, 1, 1, 8'h55, 8'hFF, 0);
        tick();
        n_tests++;
        if (out !== 8'd0 || wrap !== 1'b0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: out=%0h wrap=%b ovf=%b, required out=0 wrap=0 ovf=0",
                     out, wrap, ovf);
        end
    endtask

    task automatic test_up_count();
        int wraps = 0;
        set_in(0, 1, 1, 0, 8'd0, 8'hFF, 0);
        for (int k = 1; k <= 300; k++) begin
            tick();
            n_tests++;
            if (obs_tc !== exp_tc || out !== 8'(k % 256) || wrap !== m_wrap || ovf !== 1'b0) begin
                n_fail++;
                $display("FAIL up_count k=%0d: out=%0h tc=%b wrap=%b ovf=%b, required out=%0h tc=%b wrap=%b ovf=0",
                         k, out, obs_tc, wrap, ovf, k % 256, exp_tc, m_wrap);
            end
            if (wrap === 1'b1) wraps++;
        end
        n_tests++;
        if (wraps != 1) begin
            n_fail++;
            $display("FAIL up_wrap_count: saw %0d wrap pulses, required 1", wraps);
        end
    endtask

    task automatic test_load_down();
        set_in(0, 0, 1, 1, 8'h26, 8'h30, 0);
        tick();
        n_tests++;
        if (out !== 8'h26) begin
            n_fail++;
            $display("FAIL load_down_load: out=%0h, required 26", out);
        end
        set_in(0, 1, 0, 0, 8'h00, 8'h30, 0);
        for (int k = 0; k < 8'h27; k++) begin
            tick();
            n_tests++;
            if (out !== 8'(8'h25 - k + ((k == 8'h26) ? 8'h31 : 8'h00)) || wrap !== m_wrap
                || obs_tc !== exp_tc) begin
                n_fail++;
                $display("FAIL load_down k=%0d: out=%0h wrap=%b tc=%b, required out=%0h wrap=%b tc=%b",
                         k, out, wrap, obs_tc, m_out, m_wrap, exp_tc);
            end
        end
        n_tests++;
        if (out !== 8'h30 || wrap !== 1'b1) begin
            n_fail++;
            $display("FAIL load_down_wrap: out=%0h wrap=%b, required out=30 wrap=1", out, wrap);
        end
    endtask

    task automatic test_saturate();
        logic [7:0] exp_up [4] = '{8'd4, 8'd5, 8'd5, 8'd5};
        logic       exp_ov [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        set_in(0, 0, 1, 1, 8'd3, 8'd5, 1);
        tick();
        set_in(0, 1, 1, 0, 8'd0, 8'd5, 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            n_tests++;
            if (out !== exp_up[k] || ovf !== exp_ov[k] || wrap !== 1'b0 || obs_tc !== exp_tc) begin
                n_fail++;
                $display("FAIL sat_up k=%0d: out=%0d ovf=%b wrap=%b tc=%b, required out=%0d ovf=%b wrap=0 tc=%b",
                         k, out, ovf, wrap, obs_tc, exp_up[k], exp_ov[k], exp_tc);
            end
        end
        dir = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            n_tests++;
            if (out !== 8'(m_out) || ovf !== 1'b1 || wrap !== 1'b0) begin
                n_fail++;
                $display("FAIL sat_down k=%0d: out=%0d ovf=%b wrap=%b, required out=%0d ovf=1 wrap=0",
                         k, out, ovf, wrap, m_out);
            end
        end
        n_tests++;
        if (out !== 8'd0) begin
            n_fail++;
            $display("FAIL sat_down_floor: out=%0d, required 0", out);
        end
        set_in(0, 1, 0, 1, 8'd2, 8'd5, 1);
        tick();
        n_tests++;
        if (out !== 8'd2 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_load_clear: out=%0d ovf=%b, required out=2 ovf=0", out, ovf);
        end
    endtask

    task automatic test_clamp_limit();
        set_in(0, 0, 1, 1, 8'd200, 8'd100, 0);
        tick();
        n_tests++;
        if (out !== 8'd100) begin
            n_fail++;
            $display("FAIL clamp: out=%0d, required 100", out);
        end
        set_in(0, 1, 1, 0, 8'd0, 8'd50, 0);
        tick();
        n_tests++;
        if (out !== 8'd0 || wrap !== 1'b1 || obs_tc !== 1'b1) begin
            n_fail++;
            $display("FAIL limit_drop_up: out=%0d wrap=%b tc=%b, required out=0 wrap=1 tc=1",
                     out, wrap, obs_tc);
        end
        set_in(0, 0, 1, 1, 8'd80, 8'd100, 0);
        tick();
        set_in(0, 1, 0, 0, 8'd0, 8'd50, 0);
        tick();
        n_tests++;
        if (out !== 8'd79 || wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL limit_drop_down: out=%0d wrap=%b, required out=79 wrap=0", out, wrap);
        end
    endtask

    task automatic test_priority();
        set_in(0, 1, 1, 1, 8'd7, 8'd100, 0);
        tick();
        n_tests++;
        if (out !== 8'd7 || obs_tc !== 1'b0) begin
            n_fail++;
            $display("FAIL load_over_en: out=%0d tc=%b, required out=7 tc=0", out, obs_tc);
        end
        // Build up ovf and wrap activity, then reset on top of a load
        set_in(0, 1, 0, 1, 8'd0, 8'd0, 1);
        tick();
        load = 0;
        tick();
        sat = 0;
        tick();
        set_in(1, 1, 1, 1, 8'd9, 8'd100, 0);
        tick();
        n_tests++;
        if (out !== 8'd0 || ovf !== 1'b0 || wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_over_load: out=%0d ovf=%b wrap=%b, required out=0 ovf=0 wrap=0",
                     out, ovf, wrap);
        end
        set_in(0, 0, 0, 1, 8'd33, 8'd100, 0);
        tick();
        load = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_tests++;
            if (out !== 8'd33 || wrap !== 1'b0 || obs_tc !== 1'b0) begin
                n_fail++;
                $display("FAIL hold k=%0d: out=%0d wrap=%b tc=%b, required out=33 wrap=0 tc=0",
                         k, out, wrap, obs_tc);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            set_in(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                   1'($urandom), ($urandom_range(0, 9) == 0), 8'($urandom),
                   ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom),
                   1'($urandom));
            tick();
            n_tests++;
            if (out !== 8'(m_out) || wrap !== m_wrap || ovf !== m_ovf || obs_tc !== exp_tc) begin
                n_fail++;
                $display("FAIL random k=%0d: out=%0d wrap=%b ovf=%b tc=%b, required out=%0d wrap=%b ovf=%b tc=%b",
                         k, out, wrap, ovf, obs_tc, m_out, m_wrap, m_ovf, exp_tc);
            end
        end
        set_in(0, 0, 1, 0, 8'd0, 8'hFF, 0);
    endtask

    task automatic test_cascade();
        int unsigned ref8 = 0;
        c_rst = 1; c_en = 1;
        tick();
        c_rst = 0;
        for (int k = 0; k < 300; k++) begin
            n_tests++;
            if ({hi_out, lo_out} !== 8'(ref8) || lo_tc !== (lo_out == 4'd15)) begin
                n_fail++;
                $display("FAIL cascade k=%0d: {hi,lo}=%0h lo_tc=%b, required %0h lo_tc=%b",
                         k, {hi_out, lo_out}, lo_tc, ref8 % 256, (ref8 % 16) == 15);
            end
            tick();
            ref8 = (ref8 + 1) % 256;
        end
        c_en = 0;
    endtask

    task automatic test_cascade16();
        w_rst = 1; w_en = 1;
        tick();
        w_rst = 0;
        for (int k = 0; k < 20; k++) begin
            n_tests++;
            if (w_out !== 16'((k + 2) % 4) || w_tc !== (((k + 2) % 4) == 3)
                || w_wrap !== (k > 0 && ((k + 2) % 4) == 0)) begin
                n_fail++;
                $display("FAIL wide_period k=%0d: out=%0d tc=%b wrap=%b, required out=%0d tc=%b",
                         k, w_out, w_tc, w_wrap, (k + 2) % 4, ((k + 2) % 4) == 3);
            end
            tick();
        end
        w_en = 0;
    endtask

    initial begin
        test_reset();
        test_up_count();
        test_load_down();
        test_saturate();
        test_clamp_limit();
        test_priority();
        test_random();
        test_cascade();
        test_cascade16();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
